// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode constants, datapath widths and the
// MEM stage FSM state encodings. Imported by the MEM stage and its helpers.
package pipeline_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int OP_W   = 2;
    localparam int TMO_W  = 8;

    // Access-timeout threshold; the count is cleared on entry to ACCESS.
    localparam logic [TMO_W-1:0] TMO_LIMIT = 8'd255;

    typedef enum logic [OP_W-1:0] {
        OP_BR  = 2'b00,
        OP_ADD = 2'b01,
        OP_LDW = 2'b10,
        OP_STW = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_e;

    // True for operations that must go through data memory.
    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_LDW) || (op == OP_STW);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
    import pipeline_pkg::*;

    logic              DMEM_REQ;
    logic              DMEM_WE;
    logic [DATA_W-1:0] DMEM_ADDR;
    logic [DATA_W-1:0] DMEM_WDATA;
    logic [DATA_W-1:0] DMEM_RDATA;
    logic              DMEM_ACK;

    modport master (
        output DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA,
        input  DMEM_RDATA, DMEM_ACK
    );

    modport slave (
        input  DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_WDATA,
        output DMEM_RDATA, DMEM_ACK
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Access-timeout counter for the MEM stage. Cleared when an access starts,
// counts every ACCESS cycle that ends without an acknowledge, and saturates
// at the limit so expiry stays asserted until the stage leaves ACCESS.
module mem_timeout_ctr
    import pipeline_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;

    // Next count: clear on access entry, otherwise saturating increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {TMO_W{1'b0}};
        end else if (inc_i && (count_q != TMO_LIMIT)) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= {TMO_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == TMO_LIMIT);

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage. ALU/branch ops retire to WB in one cycle; loads and
// stores stall upstream and hold a data-memory request until acknowledged.
// Optional feature: define MEM_STAGE_TIMEOUT_EN to abandon an access that is
// not acknowledged within the timeout window and raise a sticky MEM_ERR.
module mem_stage
    import pipeline_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [OP_W-1:0]   OP_IN,
    input  logic [REG_W-1:0]  DR_IN,
    input  logic [DATA_W-1:0] ADDR_IN,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic              STALL,
    mem_stage_if.master       dmem,
    output logic [OP_W-1:0]   OP_to_WB,
    output logic [REG_W-1:0]  DR_to_WB,
    output logic [DATA_W-1:0] RESULT_to_WB,
    output logic              WB_VALID,
    output logic [DATA_W-1:0] MEM_result_forward,
    output logic              MEM_ERR
);

    mem_state_e        state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [REG_W-1:0]  dr_q, dr_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              wb_valid_q, wb_valid_d;
    logic              mem_err_q, mem_err_d;

    logic              stall_s;
    logic              req_s;
    logic              we_s;
    logic [DATA_W-1:0] fwd_s;
    logic              timeout_s;

`ifdef MEM_STAGE_TIMEOUT_EN
    logic enter_access_s;
    logic access_wait_s;

    assign enter_access_s = (state_q == ST_IDLE) && is_mem_op(OP_IN);
    assign access_wait_s  = (state_q == ST_ACCESS) && !dmem.DMEM_ACK;

    mem_timeout_ctr u_timeout_ctr (
        .CLK       (CLK),
        .RESET     (RESET),
        .clr_i     (enter_access_s),
        .inc_i     (access_wait_s),
        .expired_o (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and WB register selection; memory ops retire on ACK or timeout.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dr_d       = dr_q;
        result_d   = result_q;
        wb_valid_d = wb_valid_q;
        mem_err_d  = mem_err_q;
        stall_s    = 1'b0;
        req_s      = 1'b0;
        we_s       = 1'b0;
        fwd_s      = ADDR_IN;

        case (state_q)
            ST_IDLE: begin
                if (is_mem_op(OP_IN)) begin
                    stall_s    = 1'b1;
                    state_d    = ST_ACCESS;
                    wb_valid_d = 1'b0;
                end else begin
                    op_d       = OP_IN;
                    dr_d       = DR_IN;
                    result_d   = ADDR_IN;
                    wb_valid_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                req_s = 1'b1;
                we_s  = OP_IN[0];
                if (dmem.DMEM_ACK) begin
                    state_d    = ST_IDLE;
                    op_d       = OP_IN;
                    dr_d       = DR_IN;
                    wb_valid_d = 1'b1;
                    if (OP_IN == OP_LDW) begin
                        result_d = dmem.DMEM_RDATA;
                        fwd_s    = dmem.DMEM_RDATA;
                    end else begin
                        result_d = ADDR_IN;
                    end
                end else if (timeout_s) begin
                    // Give up on the access; loads retire with a zero value.
                    state_d    = ST_IDLE;
                    op_d       = OP_IN;
                    dr_d       = DR_IN;
                    wb_valid_d = 1'b1;
                    mem_err_d  = 1'b1;
                    if (OP_IN == OP_LDW) begin
                        result_d = 16'h0000;
                    end else begin
                        result_d = ADDR_IN;
                    end
                end else begin
                    stall_s    = 1'b1;
                    wb_valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wb_valid_d = 1'b0;
            end
        endcase
    end

    // Stage registers; reset abandons any in-flight access immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            op_q       <= 2'b00;
            dr_q       <= 3'b000;
            result_q   <= 16'h0000;
            wb_valid_q <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dr_q       <= dr_d;
            result_q   <= result_d;
            wb_valid_q <= wb_valid_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign STALL              = stall_s;
    assign dmem.DMEM_REQ      = req_s;
    assign dmem.DMEM_WE       = we_s;
    assign dmem.DMEM_ADDR     = ADDR_IN;
    assign dmem.DMEM_WDATA    = DATA_IN;
    assign MEM_result_forward = fwd_s;
    assign OP_to_WB           = op_q;
    assign DR_to_WB           = dr_q;
    assign RESULT_to_WB       = result_q;
    assign WB_VALID           = wb_valid_q;
    assign MEM_ERR            = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a WB-result scoreboard.
module tb_mem_stage;
    import pipeline_pkg::*;

    logic        CLK;
    logic        RESET;
    logic [1:0]  OP_IN;
    logic [2:0]  DR_IN;
    logic [15:0] ADDR_IN;
    logic [15:0] DATA_IN;
    logic        STALL;
    logic [1:0]  OP_to_WB;
    logic [2:0]  DR_to_WB;
    logic [15:0] RESULT_to_WB;
    logic        WB_VALID;
    logic [15:0] MEM_result_forward;
    logic        MEM_ERR;

    mem_stage_if dmem_bus ();

    mem_stage dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .OP_IN              (OP_IN),
        .DR_IN              (DR_IN),
        .ADDR_IN            (ADDR_IN),
        .DATA_IN            (DATA_IN),
        .STALL              (STALL),
        .dmem               (dmem_bus.master),
        .OP_to_WB           (OP_to_WB),
        .DR_to_WB           (DR_to_WB),
        .RESULT_to_WB       (RESULT_to_WB),
        .WB_VALID           (WB_VALID),
        .MEM_result_forward (MEM_result_forward),
        .MEM_ERR            (MEM_ERR)
    );

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  dr;
        logic [15:0] res;
    } wb_t;

    wb_t sb[$];
    int  checks   = 0;
    int  failures = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called just after the retiring edge: pop the expected entry and compare.
    task automatic retire_check(input string tag);
        wb_t e;
        chk16({tag, "_sbq"}, 16'(sb.size()), 16'd1);
        chk1({tag, "_valid"}, WB_VALID, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk16({tag, "_res"}, RESULT_to_WB, e.res);
            chk16({tag, "_dr"}, 16'(DR_to_WB), 16'(e.dr));
            chk16({tag, "_op"}, 16'(OP_to_WB), 16'(e.op));
        end
    endtask

    // Non-memory op issued at posedge+1; retires one edge later.
    task automatic run_alu(input logic [1:0] op, input logic [2:0] dr,
                           input logic [15:0] addr, input logic stray_ack,
                           input string tag);
        OP_IN   = op;
        DR_IN   = dr;
        ADDR_IN = addr;
        DATA_IN = 16'hDEAD;
        dmem_bus.DMEM_ACK   = stray_ack;
        dmem_bus.DMEM_RDATA = 16'hFFFF;
        sb.push_back('{op: op, dr: dr, res: addr});
        @(negedge CLK);
        chk1({tag, "_stall"}, STALL, 1'b0);
        chk1({tag, "_req"}, dmem_bus.DMEM_REQ, 1'b0);
        chk16({tag, "_fwd"}, MEM_result_forward, addr);
        @(posedge CLK);
        #1;
        dmem_bus.DMEM_ACK = 1'b0;
        retire_check(tag);
    endtask

    // Load/store with 'delay' unacknowledged ACCESS cycles before the ACK cycle.
    task automatic run_mem(input logic [1:0] op, input logic [2:0] dr,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] rdata, input int delay,
                           input string tag);
        int stalls;
        logic [15:0] exp_res;
        stalls  = 0;
        exp_res = (op == OP_LDW) ? rdata : addr;
        OP_IN   = op;
        DR_IN   = dr;
        ADDR_IN = addr;
        DATA_IN = wdata;
        dmem_bus.DMEM_ACK = 1'b0;
        sb.push_back('{op: op, dr: dr, res: exp_res});
        @(negedge CLK);
        if (STALL) stalls++;
        chk1({tag, "_idle_req"}, dmem_bus.DMEM_REQ, 1'b0);
        chk1({tag, "_idle_we"}, dmem_bus.DMEM_WE, 1'b0);
        @(posedge CLK);
        #1;
        for (int k = 0; k < delay; k++) begin
            @(negedge CLK);
            if (STALL) stalls++;
            chk1({tag, "_req"}, dmem_bus.DMEM_REQ, 1'b1);
            @(posedge CLK);
            #1;
            chk1({tag, "_bubble"}, WB_VALID, 1'b0);
        end
        dmem_bus.DMEM_ACK   = 1'b1;
        dmem_bus.DMEM_RDATA = rdata;
        @(negedge CLK);
        if (STALL) stalls++;
        chk1({tag, "_ack_req"}, dmem_bus.DMEM_REQ, 1'b1);
        chk1({tag, "_we"}, dmem_bus.DMEM_WE, (op == OP_STW));
        chk16({tag, "_addr"}, dmem_bus.DMEM_ADDR, addr);
        chk16({tag, "_wdata"}, dmem_bus.DMEM_WDATA, wdata);
        chk16({tag, "_fwd"}, MEM_result_forward, exp_res);
        chk16({tag, "_stalls"}, 16'(stalls), 16'(delay + 1));
        @(posedge CLK);
        #1;
        dmem_bus.DMEM_ACK = 1'b0;
        retire_check(tag);
    endtask

    initial begin
        RESET   = 1'b1;
        OP_IN   = OP_BR;
        DR_IN   = 3'd0;
        ADDR_IN = 16'h0000;
        DATA_IN = 16'h0000;
        dmem_bus.DMEM_ACK   = 1'b0;
        dmem_bus.DMEM_RDATA = 16'h0000;

        @(negedge CLK);
        chk1("rst_valid", WB_VALID, 1'b0);
        chk16("rst_res", RESULT_to_WB, 16'h0000);
        chk16("rst_op", 16'(OP_to_WB), 16'h0000);
        chk16("rst_dr", 16'(DR_to_WB), 16'h0000);
        chk1("rst_err", MEM_ERR, 1'b0);
        chk1("rst_req", dmem_bus.DMEM_REQ, 1'b0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        run_alu(OP_ADD, 3'd3, 16'h1234, 1'b0, "add");
        run_mem(OP_LDW, 3'd5, 16'h0040, 16'h0000, 16'hBEEF, 3, "ldw");
        run_mem(OP_STW, 3'd1, 16'h0080, 16'h5A5A, 16'h0000, 0, "stw");
        run_alu(OP_BR, 3'd0, 16'h00F0, 1'b0, "br");
        run_alu(OP_ADD, 3'd7, 16'hA5A5, 1'b1, "stray");
        run_alu(OP_ADD, 3'd2, 16'h0001, 1'b0, "post_stray");
        run_mem(OP_LDW, 3'd4, 16'h0102, 16'h0000, 16'h1357, 1, "ldw2");

        // Reset in the middle of an access.
        OP_IN   = OP_LDW;
        DR_IN   = 3'd4;
        ADDR_IN = 16'h0100;
        @(negedge CLK);
        chk1("rstmid_stall", STALL, 1'b1);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk1("rstmid_req_before", dmem_bus.DMEM_REQ, 1'b1);
        #1;
        RESET = 1'b1;
        #1;
        chk1("rstmid_req", dmem_bus.DMEM_REQ, 1'b0);
        chk1("rstmid_valid", WB_VALID, 1'b0);
        chk16("rstmid_res", RESULT_to_WB, 16'h0000);
        chk16("rstmid_op", 16'(OP_to_WB), 16'h0000);
        chk16("rstmid_dr", 16'(DR_to_WB), 16'h0000);
        chk1("rstmid_err", MEM_ERR, 1'b0);
        #1;
        RESET   = 1'b0;
        OP_IN   = OP_ADD;
        DR_IN   = 3'd6;
        ADDR_IN = 16'h0BAD;
        sb.push_back('{op: OP_ADD, dr: 3'd6, res: 16'h0BAD});
        @(negedge CLK);
        chk1("rstadd_stall", STALL, 1'b0);
        @(posedge CLK);
        #1;
        retire_check("rstadd");

`ifdef MEM_STAGE_TIMEOUT_EN
        begin
            int n;
            n = 0;
            OP_IN   = OP_LDW;
            DR_IN   = 3'd2;
            ADDR_IN = 16'h0200;
            sb.push_back('{op: OP_LDW, dr: 3'd2, res: 16'h0000});
            @(negedge CLK);
            chk1("tmo_idle_stall", STALL, 1'b1);
            @(posedge CLK);
            #1;
            for (int i = 0; i < 400; i++) begin
                @(negedge CLK);
                if (!STALL) break;
                n++;
                @(posedge CLK);
                #1;
            end
            chk16("tmo_cycles", 16'(n), 16'd255);
            @(posedge CLK);
            #1;
            chk1("tmo_err", MEM_ERR, 1'b1);
            chk1("tmo_req", dmem_bus.DMEM_REQ, 1'b0);
            retire_check("tmo");
            run_alu(OP_ADD, 3'd1, 16'h0042, 1'b0, "tmo_after");
            chk1("tmo_err_hold", MEM_ERR, 1'b1);
            OP_IN = OP_BR;
            RESET = 1'b1;
            #1;
            chk1("tmo_err_rst", MEM_ERR, 1'b0);
            RESET = 1'b0;
        end
`endif

        chk16("sb_drained", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
